// File: rtl/piso_serializer_8bit.sv
// Purpose: parallel-in/serial-out shifter with Load/Ready capture and Busy/Done frame status; optional parity bit via PISO_PARITY_EN.
// Latency: first bit on Sout the cycle after acceptance; Done pulses WIDTH*BIT_CYCLES+1 cycles after acceptance (+BIT_CYCLES with parity).
// Backpressure: Ready is high only in IDLE; a Load seen while Ready=0 is dropped, not queued.
module piso_serializer_8bit #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 4,
  parameter int LSB_FIRST  = 1
) (
  input  logic             CLK,
  input  logic             Asynch_clr_n,
  input  logic [WIDTH-1:0] D,
  input  logic             Load,
  output logic             Ready,
  output logic             Sout,
  output logic             Busy,
  output logic             Done
);

  localparam int DW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(BIT_CYCLES - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_PARITY = 2'd2, S_DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd3} state_t;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [DW-1:0]    div_cnt;
  logic [BW-1:0]    bit_cnt;
  logic             sout_q;
  logic             div_last;
  logic             bit_last;
`ifdef PISO_PARITY_EN
  logic             par_q;
`endif

  assign div_last = (div_cnt == DIV_LAST);
  assign bit_last = (bit_cnt == BIT_LAST);
  assign Sout     = sout_q;

  // State register; reset aborts any frame in progress.
  always_ff @(posedge CLK or negedge Asynch_clr_n) begin
    if (!Asynch_clr_n) state <= S_IDLE;
    else               state <= state_nxt;
  end

  // Next-state and status outputs decoded from the current state.
  always_comb begin
    state_nxt = state;
    Ready     = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state)
      S_IDLE: begin
        Ready = 1'b1;
        if (Load) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        Busy = 1'b1;
        if (div_last && bit_last) begin
`ifdef PISO_PARITY_EN
          state_nxt = S_PARITY;
`else
          state_nxt = S_DONE;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      S_PARITY: begin
        Busy = 1'b1;
        if (div_last) state_nxt = S_DONE;
      end
`endif
      S_DONE: begin
        Done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: capture on acceptance, hold each bit BIT_CYCLES clocks, idle high.
  always_ff @(posedge CLK or negedge Asynch_clr_n) begin
    if (!Asynch_clr_n) begin
      shreg   <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      sout_q  <= 1'b1;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          sout_q <= 1'b1;
          if (Load) begin
            shreg   <= D;
            div_cnt <= '0;
            bit_cnt <= '0;
            sout_q  <= (LSB_FIRST != 0) ? D[0] : D[WIDTH-1];
`ifdef PISO_PARITY_EN
            par_q   <= ^D;
`endif
          end
        end
        S_SHIFT: begin
          if (div_last) begin
            div_cnt <= '0;
            if (bit_last) begin
              bit_cnt <= '0;
`ifdef PISO_PARITY_EN
              sout_q  <= par_q;
`else
              sout_q  <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + BIT_ONE;
              // The head of the register is the bit now on Sout; its neighbour goes next.
              shreg   <= (LSB_FIRST != 0) ? (shreg >> 1) : (shreg << 1);
              sout_q  <= (LSB_FIRST != 0) ? shreg[1] : shreg[WIDTH-2];
            end
          end else begin
            div_cnt <= div_cnt + DIV_ONE;
          end
        end
`ifdef PISO_PARITY_EN
        S_PARITY: begin
          if (div_last) begin
            div_cnt <= '0;
            sout_q  <= 1'b1;
          end else begin
            div_cnt <= div_cnt + DIV_ONE;
          end
        end
`endif
        default: sout_q <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer_8bit.sv
// Purpose: self-checking bench for piso_serializer_8bit, scoreboard of expected serial bits.
// Latency: cycle k of a frame is sampled on the falling edge after acceptance edge E0+k-1.
// Backpressure: Load pulses during a frame must not disturb the scoreboard stream.
module tb_piso_serializer_8bit;

  localparam int BC = 4;
`ifdef PISO_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       CLK = 1'b0;
  logic       Asynch_clr_n = 1'b1;
  logic [7:0] D = 8'h00;
  logic       Load = 1'b0;
  logic       Ready, Sout, Busy, Done;
  logic [7:0] m_d = 8'h00;
  logic       m_load = 1'b0;
  logic       m_ready, m_sout, m_busy, m_done;
  bit         clk_run = 1'b0;

  int total  = 0;
  int passed = 0;
  bit exp_q[$];

  piso_serializer_8bit #(.WIDTH(8), .BIT_CYCLES(BC), .LSB_FIRST(1)) dut (
    .CLK(CLK), .Asynch_clr_n(Asynch_clr_n), .D(D), .Load(Load),
    .Ready(Ready), .Sout(Sout), .Busy(Busy), .Done(Done)
  );

  piso_serializer_8bit #(.WIDTH(8), .BIT_CYCLES(BC), .LSB_FIRST(0)) dut_msb (
    .CLK(CLK), .Asynch_clr_n(Asynch_clr_n), .D(m_d), .Load(m_load),
    .Ready(m_ready), .Sout(m_sout), .Busy(m_busy), .Done(m_done)
  );

  // Clock can be stopped to show reset acts without edges.
  always #5 if (clk_run) CLK = ~CLK;

  // Expected LSB-first stream for one frame, parity bit appended when enabled.
  task automatic push_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) exp_q.push_back(w[i]);
`ifdef PISO_PARITY_EN
    exp_q.push_back(^w);
`endif
  endtask

  // Follows one frame from just after its acceptance edge to the Ready cycle.
  task automatic consume_frame(input string name);
    logic [3:0] obs;
    for (int k = 1; k <= NB*BC; k++) begin
      @(negedge CLK);
      obs = {Sout, Ready, Busy, Done};
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL %s cycle %0d: scoreboard empty, got %b", name, k, obs);
      end else if (obs !== {exp_q[0], 3'b010}) begin
        $display("FAIL %s cycle %0d: {Sout,Ready,Busy,Done}=%b expected %b",
                 name, k, obs, {exp_q[0], 3'b010});
      end else begin
        passed++;
      end
      if ((k % BC) == 0 && exp_q.size() > 0) void'(exp_q.pop_front());
    end
    @(negedge CLK);
    obs = {Sout, Ready, Busy, Done};
    total++;
    if (obs !== 4'b1001) $display("FAIL %s done cycle: got %b expected 1001", name, obs);
    else passed++;
    @(negedge CLK);
    obs = {Sout, Ready, Busy, Done};
    total++;
    if (obs !== 4'b1100) $display("FAIL %s ready cycle: got %b expected 1100", name, obs);
    else passed++;
  endtask

  task automatic test_reset();
    #3 Asynch_clr_n = 1'b0;
    #2;
    total++;
    if ({Sout, Ready, Busy, Done, m_sout, m_ready, m_busy, m_done} !== 8'b1100_1100)
      $display("FAIL reset_no_clock: got %b expected 11001100",
               {Sout, Ready, Busy, Done, m_sout, m_ready, m_busy, m_done});
    else passed++;
    #5 Asynch_clr_n = 1'b1;
    clk_run = 1'b1;
    repeat (2) @(negedge CLK);
    total++;
    if ({Sout, Ready, Busy, Done} !== 4'b1100)
      $display("FAIL reset_idle_clocked: got %b expected 1100", {Sout, Ready, Busy, Done});
    else passed++;
  endtask

  task automatic test_single_frame();
    D = 8'hA5; Load = 1'b1; push_word(8'hA5);
    @(posedge CLK); #1 Load = 1'b0;
    consume_frame("single_a5");
  endtask

  task automatic test_ignored_load();
    D = 8'hA5; Load = 1'b1; push_word(8'hA5);
    @(posedge CLK); #1 Load = 1'b0;
    fork
      consume_frame("ignored_load");
      begin
        repeat (10) @(negedge CLK);
        #1 D = 8'hFF; Load = 1'b1;
        @(negedge CLK);
        #1 Load = 1'b0; D = 8'h00;
      end
    join
  endtask

  task automatic test_back_to_back();
    D = 8'h3C; Load = 1'b1; push_word(8'h3C);
    @(posedge CLK); #1 D = 8'hC3;
    consume_frame("b2b_first");
    push_word(8'hC3);
    @(posedge CLK);
    consume_frame("b2b_second");
    Load = 1'b0;
    @(negedge CLK);
    total++;
    if ({Sout, Ready, Busy, Done} !== 4'b1100)
      $display("FAIL b2b_no_third: got %b expected 1100", {Sout, Ready, Busy, Done});
    else passed++;
  endtask

  task automatic test_midframe_reset();
    logic [3:0] obs;
    D = 8'hA5; Load = 1'b1; push_word(8'hA5);
    @(posedge CLK); #1 Load = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge CLK);
      obs = {Sout, Ready, Busy, Done};
      total++;
      if (obs !== {exp_q[0], 3'b010})
        $display("FAIL prereset cycle %0d: got %b expected %b", k, obs, {exp_q[0], 3'b010});
      else passed++;
      if ((k % BC) == 0) void'(exp_q.pop_front());
    end
    #2 Asynch_clr_n = 1'b0;
    #1;
    total++;
    if ({Sout, Ready, Busy, Done} !== 4'b1100)
      $display("FAIL midframe_reset: got %b expected 1100", {Sout, Ready, Busy, Done});
    else passed++;
    exp_q.delete();
    @(negedge CLK);
    Asynch_clr_n = 1'b1;
    D = 8'h01; Load = 1'b1; push_word(8'h01);
    @(posedge CLK); #1 Load = 1'b0;
    consume_frame("after_reset_01");
  endtask

`ifdef PISO_PARITY_EN
  task automatic test_parity();
    D = 8'h07; Load = 1'b1; push_word(8'h07);
    @(posedge CLK); #1 Load = 1'b0;
    consume_frame("parity_07");
  endtask
`endif

  task automatic test_msb_first();
    logic [7:0] w;
    int n;
    w = 8'h80;
    m_d = w; m_load = 1'b1;
    @(posedge CLK); #1 m_load = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK);
      total++;
      if (m_sout !== w[7 - ((k - 1) / BC)])
        $display("FAIL msb_first cycle %0d: Sout=%b expected %b", k, m_sout, w[7 - ((k - 1) / BC)]);
      else passed++;
    end
    n = 8;
    while (m_done !== 1'b1 && n < 60) begin
      @(negedge CLK);
      n++;
    end
    total++;
    if (n !== NB*BC + 1)
      $display("FAIL msb_done_cycle: Done seen at cycle %0d expected %0d", n, NB*BC + 1);
    else passed++;
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_ignored_load();
    test_back_to_back();
    test_midframe_reset();
`ifdef PISO_PARITY_EN
    test_parity();
`endif
    test_msb_first();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
